// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: sequential unsigned WIDTHxWIDTH shift-add multiplier
// owning the architectural HI/LO pair, with MFHI/MFLO read and stall.
// Optional build macro: MULTU_EARLY_EXIT_EN. When it is defined, RUN also
// ends as soon as the remaining multiplier bits are all zero.
// Handshake: Mult_op==MULTU_CODE in IDLE starts a multiply. Done stays high
// until Mult_op leaves MULTU_CODE. Stall is high whenever Sel asks for a
// read while Busy is high, because HI/LO still hold the previous result.
module multu_hilo_unit #(
    parameter int          WIDTH      = 32,
    parameter logic [5:0]  MULTU_CODE = 6'b011001
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [5:0]       Mult_op,
    input  logic [WIDTH-1:0] Op_a,
    input  logic [WIDTH-1:0] Op_b,
    input  logic [1:0]       Sel,
    output logic [WIDTH-1:0] Hilo_out,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mplier_shift;
    logic [CW-1:0]        count;
    logic                 start;
    logic                 last_iter;

    // Per-iteration arithmetic and the exit condition of the current RUN edge
    always_comb begin
        acc_sum      = mplier[0] ? (acc + mcand) : acc;
        mplier_shift = mplier >> 1;
        start        = (Mult_op == MULTU_CODE);
`ifdef MULTU_EARLY_EXIT_EN
        last_iter    = (count == CW'(WIDTH - 1)) || (mplier_shift == '0);
`else
        last_iter    = (count == CW'(WIDTH - 1));
`endif
    end

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Mult_op is ignored while RUN is in flight
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)     state_next = ST_RUN;
            ST_RUN:  if (last_iter) state_next = ST_DONE;
            ST_DONE: if (!start)    state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Shift-add datapath: operands are captured only on the start edge
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, Op_a};
                mplier <= Op_b;
                count  <= '0;
            end else if (state == ST_RUN) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier_shift;
                count  <= count + CW'(1);
            end
        end
    end

    // HI/LO commit on the edge that leaves RUN, including that edge's add
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Hi <= '0;
            Lo <= '0;
        end else if (state == ST_RUN && last_iter) begin
            {Hi, Lo} <= acc_sum;
        end
    end

    // Status, stall and MFHI/MFLO read mux
    always_comb begin
        Busy      = (state == ST_RUN);
        Done      = (state == ST_DONE);
        Stall     = Busy && (Sel == 2'b01 || Sel == 2'b10);
        dbg_state = state;
        case (Sel)
            2'b01:   Hilo_out = Hi;
            2'b10:   Hilo_out = Lo;
            default: Hilo_out = '0;
        endcase
    end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit: directed + random checks of multu_hilo_unit against
// a plain-arithmetic product and latency model.
module tb_multu_hilo_unit;

    localparam int W = 32;
    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] HILO  = 6'd63;

    logic          Clk;
    logic          Rst_n;
    logic [5:0]    Mult_op;
    logic [W-1:0]  Op_a;
    logic [W-1:0]  Op_b;
    logic [1:0]    Sel;
    logic [W-1:0]  Hilo_out;
    logic [W-1:0]  Hi;
    logic [W-1:0]  Lo;
    logic          Busy;
    logic          Done;
    logic          Stall;
    logic [1:0]    dbg_state;

    int            n_cmp;
    int            n_bad;
    logic [63:0]   exp_q[$];
    logic [W-1:0]  prev_hi;
    logic [W-1:0]  prev_lo;

    multu_hilo_unit #(.WIDTH(W), .MULTU_CODE(MULTU)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Mult_op(Mult_op), .Op_a(Op_a), .Op_b(Op_b),
        .Sel(Sel), .Hilo_out(Hilo_out), .Hi(Hi), .Lo(Lo), .Busy(Busy),
        .Done(Done), .Stall(Stall), .dbg_state(dbg_state)
    );

    // clock / reset block
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: cycles from the start edge to the commit edge
    function automatic int ref_latency(input logic [W-1:0] b);
`ifdef MULTU_EARLY_EXIT_EN
        int top;
        top = 0;
        for (int i = 0; i < W; i++) if (b[i]) top = i + 1;
        return (top < 1) ? 1 : top;
`else
        return (b == 0) ? W : W;
`endif
    endfunction

    function automatic logic [63:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] wa, wb;
        wa = {32'b0, a};
        wb = {32'b0, b};
        return wa * wb;
    endfunction

    // driver: run one multiply, check stall/read during RUN, latency, result
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int          lat;
        int          n;
        logic [63:0] prod;
        lat  = ref_latency(b);
        exp_q.push_back(ref_product(a, b));
        @(negedge Clk);
        Op_a    = a;
        Op_b    = b;
        Mult_op = MULTU;
        Sel     = 2'b00;
        @(posedge Clk);                       // E0
        #1;
        Op_a = $urandom;                      // must not affect the product
        Op_b = $urandom;
        Sel  = 2'b01;
        #1;
        check({tag, "_busy_e0"}, {63'b0, Busy}, 64'd1);
        check({tag, "_stall_rd_hi"}, {63'b0, Stall}, 64'd1);
        check({tag, "_old_hi"}, {32'b0, Hilo_out}, {32'b0, prev_hi});
        Sel = 2'b00;
        n = 0;
        while (n < 100) begin
            @(posedge Clk);
            #1;
            n++;
            if (Done) break;
        end
        prod = exp_q.pop_front();
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_busy_done"}, {62'b0, Busy, Stall}, 64'd0);
        check({tag, "_hilo"}, {Hi, Lo}, prod);
        Sel = 2'b10;
        #1;
        check({tag, "_rd_lo"}, {31'b0, Stall, Hilo_out}, {32'b0, prod[31:0]});
        Sel = 2'b01;
        #1;
        check({tag, "_rd_hi"}, {32'b0, Hilo_out}, {32'b0, prod[63:32]});
        Sel = 2'b11;
        #1;
        check({tag, "_rd_none"}, {32'b0, Hilo_out}, 64'd0);
        Sel = 2'b00;
        prev_hi = prod[63:32];
        prev_lo = prod[31:0];
    endtask

    task automatic release_done(input string tag);
        @(negedge Clk);
        Mult_op = HILO;
        @(posedge Clk);
        #1;
        check({tag, "_to_idle"}, {62'b0, Busy, Done}, 64'd0);
        @(negedge Clk);
        Mult_op = 6'd0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         all_done;
        logic         any_busy;
        n_cmp   = 0;
        n_bad   = 0;
        prev_hi = '0;
        prev_lo = '0;
        Rst_n   = 1'b0;
        Mult_op = 6'd0;
        Op_a    = '0;
        Op_b    = '0;
        Sel     = 2'b01;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_outputs", {Hi, Lo}, 64'd0);
        check("reset_status", {29'b0, Busy, Done, Stall, Hilo_out}, 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        Sel   = 2'b00;

        // basic product, then HILO code releases DONE
        run_mult(32'd3, 32'd5, "basic");
        release_done("basic");

        // maximum operands
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
        release_done("max");

        // zero multiplier
        run_mult(32'h1234_5678, 32'd0, "zero_b");
        release_done("zero_b");

        // level-held request after commit: no restart, HI/LO frozen
        run_mult(32'hDEAD_BEEF, 32'h0000_0F0F, "held");
        all_done = 1'b1;
        any_busy = 1'b0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            all_done = all_done & Done;
            any_busy = any_busy | Busy;
        end
        check("held_stays_done", {62'b0, all_done, any_busy}, 64'd2);
        check("held_hilo_frozen", {Hi, Lo}, {prev_hi, prev_lo});
        release_done("held");

        // random operands
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_mult(ra, rb, "rand");
            release_done("rand");
        end

        // reset mid-multiply at E10
        @(negedge Clk);
        Op_a    = 32'h0BAD_F00D;
        Op_b    = 32'h8000_0001;
        Mult_op = MULTU;
        Sel     = 2'b01;
        @(posedge Clk);
        repeat (10) @(posedge Clk);
        #1;
        check("pre_reset_busy", {63'b0, Busy}, 64'd1);
        Rst_n = 1'b0;
        #1;
        check("async_reset_hilo", {Hi, Lo}, 64'd0);
        check("async_reset_status", {29'b0, Busy, Done, Stall, Hilo_out}, 64'd0);
        @(negedge Clk);
        Mult_op = 6'd0;
        Rst_n   = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        check("post_reset_idle", {62'b0, Busy, Done}, 64'd0);
        check("post_reset_hilo", {Hi, Lo}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
